// File: rtl/traffic_pkg.sv
// traffic_pkg: phase encoding, lamp bit order and helpers shared by the traffic controller
package traffic_pkg;
  typedef enum logic [1:0] {PH_ALL_RED = 2'd0, PH_GREEN = 2'd1, PH_YELLOW = 2'd2} phase_e;
  typedef struct packed {
    logic red;
    logic yellow;
    logic straight;
    logic right;
  } lamp_t;
  localparam lamp_t LAMP_RED = lamp_t'(4'b1000);
  function automatic lamp_t lamp_of(phase_e ph, logic right);
    return (ph == PH_GREEN) ? lamp_t'({3'b001, right}) : (ph == PH_YELLOW) ? lamp_t'(4'b0100) : LAMP_RED;
  endfunction
  function automatic int max3(int a, int b, int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: down-counter that flags the last cycle of a loaded phase length
module phase_timer #(
  parameter int W = 8,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         hold,
  output logic         timeout
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_value : (hold || cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= W'(RST_VAL);
    else cnt_q <= cnt_d;
  assign timeout = cnt_q <= W'(1);
endmodule

// File: rtl/adaptive_traffic_controller.sv
// adaptive_traffic_controller: sensor-scaled green, gap-out and emergency preemption for NUM_DIR approaches
module adaptive_traffic_controller
  import traffic_pkg::*;
#(
  parameter int NUM_DIR     = 4,
  parameter int SENS_W      = 2,
  parameter int BASE_GREEN  = 20,
  parameter int STEP_GREEN  = 10,
  parameter int MIN_GREEN   = 10,
  parameter int RIGHT_TIME  = 8,
  parameter int YELLOW_TIME = 5,
  parameter int ALLRED_TIME = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_DIR*SENS_W-1:0]   sensor,
  input  logic [NUM_DIR-1:0]          emerg_req,
  output logic [NUM_DIR-1:0]          light_red,
  output logic [NUM_DIR-1:0]          light_yellow,
  output logic [NUM_DIR-1:0]          light_green_straight,
  output logic [NUM_DIR-1:0]          light_green_right,
  output logic [$clog2(NUM_DIR)-1:0]  active_dir,
  output logic [1:0]                  phase,
  output logic                        emerg_active
);
  localparam int DW = $clog2(NUM_DIR);
  localparam int GMAX = BASE_GREEN + (2**SENS_W - 1) * STEP_GREEN;
  localparam int TW = $clog2(max3(GMAX, YELLOW_TIME, ALLRED_TIME) + 1);
  localparam int AW = $clog2(MIN_GREEN + 2);
  localparam int RW = $clog2(RIGHT_TIME + 2);
  phase_e phase_q, phase_d;
  logic [DW-1:0] dir_q, dir_d, sel_dir, em_dir;
  logic [SENS_W-1:0] sel_lvl, entry_lvl;
  logic em_q, em_d, em_any, own_idle, other_busy, other_em, gap_ok;
  logic [AW-1:0] age_q, age_d;
  logic [RW-1:0] rleft_q, rleft_d;
  logic [NUM_DIR-1:0] red_q, red_d, yellow_q, yellow_d, straight_q, straight_d, right_q, right_d;
  logic load, hold, timeout;
  logic [TW-1:0] load_val, glen;
  phase_timer #(.W(TW), .RST_VAL(ALLRED_TIME)) u_timer (
    .clk(clk), .reset(reset), .load(load), .load_value(load_val), .hold(hold), .timeout(timeout)
  );
  // Round-robin search from the next direction; the active one is tried last
  always_comb begin
    sel_dir = (dir_q == DW'(NUM_DIR - 1)) ? '0 : dir_q + 1'b1;
    sel_lvl = '0;
    for (int i = NUM_DIR; i >= 1; i--)
      if (sensor[((int'(dir_q) + i) % NUM_DIR) * SENS_W +: SENS_W] != '0) begin
        sel_dir = DW'((int'(dir_q) + i) % NUM_DIR);
        sel_lvl = sensor[((int'(dir_q) + i) % NUM_DIR) * SENS_W +: SENS_W];
      end
    em_dir = '0;
    for (int i = NUM_DIR - 1; i >= 0; i--)
      if (emerg_req[i]) em_dir = DW'(i);
    other_busy = 1'b0;
    for (int i = 0; i < NUM_DIR; i++)
      if (DW'(i) != dir_q && sensor[i*SENS_W +: SENS_W] != '0) other_busy = 1'b1;
  end
  assign em_any    = |emerg_req;
  assign entry_lvl = em_any ? sensor[em_dir*SENS_W +: SENS_W] : sel_lvl;
  assign glen      = TW'(BASE_GREEN + int'(entry_lvl) * STEP_GREEN);
  assign own_idle  = sensor[dir_q*SENS_W +: SENS_W] == '0;
  assign other_em  = |(emerg_req & ~(NUM_DIR'(1) << dir_q));
  assign gap_ok    = int'(age_q) + 1 >= MIN_GREEN;
  always_comb begin
    phase_d  = phase_q;
    dir_d    = dir_q;
    em_d     = em_q;
    age_d    = age_q;
    rleft_d  = rleft_q;
    load     = 1'b0;
    load_val = glen;
    hold     = 1'b0;
    case (phase_q)
      PH_ALL_RED: if (timeout) begin
        phase_d = PH_GREEN;
        dir_d   = em_any ? em_dir : sel_dir;
        em_d    = em_any;
        load    = 1'b1;
        age_d   = '0;
        rleft_d = RW'((int'(glen) < RIGHT_TIME) ? int'(glen) : RIGHT_TIME);
      end
      PH_GREEN: begin
        hold    = em_q;
        age_d   = (int'(age_q) < MIN_GREEN) ? age_q + 1'b1 : age_q;
        rleft_d = (rleft_q != '0) ? rleft_q - 1'b1 : rleft_q;
        // A preemption green ignores the timer and other requests until its own request drops
        if (em_q ? !emerg_req[dir_q] : (timeout || other_em || (gap_ok && own_idle && other_busy))) begin
          phase_d  = PH_YELLOW;
          em_d     = 1'b0;
          load     = 1'b1;
          load_val = TW'(YELLOW_TIME);
        end
      end
      PH_YELLOW: if (timeout) begin
        phase_d  = PH_ALL_RED;
        load     = 1'b1;
        load_val = TW'(ALLRED_TIME);
      end
      default: begin
        phase_d  = PH_ALL_RED;
        load     = 1'b1;
        load_val = TW'(ALLRED_TIME);
      end
    endcase
  end
  always_comb begin
    red_d      = '1;
    yellow_d   = '0;
    straight_d = '0;
    right_d    = '0;
    for (int d = 0; d < NUM_DIR; d++)
      {red_d[d], yellow_d[d], straight_d[d], right_d[d]} =
        (DW'(d) == dir_d) ? lamp_of(phase_d, rleft_d != '0) : LAMP_RED;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      phase_q    <= PH_ALL_RED;
      dir_q      <= DW'(NUM_DIR - 1);
      em_q       <= 1'b0;
      age_q      <= '0;
      rleft_q    <= '0;
      red_q      <= '1;
      yellow_q   <= '0;
      straight_q <= '0;
      right_q    <= '0;
    end else begin
      phase_q    <= phase_d;
      dir_q      <= dir_d;
      em_q       <= em_d;
      age_q      <= age_d;
      rleft_q    <= rleft_d;
      red_q      <= red_d;
      yellow_q   <= yellow_d;
      straight_q <= straight_d;
      right_q    <= right_d;
    end
  assign light_red            = red_q;
  assign light_yellow         = yellow_q;
  assign light_green_straight = straight_q;
  assign light_green_right    = right_q;
  assign active_dir           = dir_q;
  assign phase                = phase_q;
  assign emerg_active         = em_q;
endmodule

// File: tb/tb_adaptive_traffic_controller.sv
// tb_adaptive_traffic_controller: phase-level model plus directed scenarios for the traffic controller
module tb_adaptive_traffic_controller;
  localparam int N = 4, SW = 2, BASE = 20, STEP = 10, MING = 10, RT = 8, YT = 5, ART = 3;
  typedef struct {
    int ph;
    int dir;
    int el;
    int len;
    bit em;
  } mstate_t;
  logic clk = 1'b0, reset = 1'b0;
  logic [7:0] sensor = '0;
  logic [3:0] emerg = '0;
  logic [3:0] red, yel, gs, gr;
  logic [1:0] adir, ph;
  logic ea;
  int n_cmp = 0, n_bad = 0;
  int n, nr;
  mstate_t m = '{0, N - 1, 0, ART, 1'b0};
  adaptive_traffic_controller dut (
    .clk(clk), .reset(reset), .sensor(sensor), .emerg_req(emerg),
    .light_red(red), .light_yellow(yel), .light_green_straight(gs), .light_green_right(gr),
    .active_dir(adir), .phase(ph), .emerg_active(ea)
  );
  always #5 clk = ~clk;
  function automatic int lvl(logic [7:0] s, int d);
    return int'((s >> (d * SW)) & 8'h3);
  endfunction
  function automatic mstate_t model_next(mstate_t s, logic [7:0] sen, logic [3:0] em);
    mstate_t r = s;
    int done = s.el + 1;
    int pick = -1;
    bit others = 1'b0;
    bit cut;
    r.el = done;
    if (s.ph == 0) begin
      if (done >= ART) begin
        r.ph = 1;
        r.el = 0;
        r.em = em != 0;
        if (em != 0) begin
          for (int k = 0; k < N; k++) if (pick < 0 && em[k]) pick = k;
        end else begin
          for (int k = 1; k <= N; k++) if (pick < 0 && lvl(sen, (s.dir + k) % N) != 0) pick = (s.dir + k) % N;
          if (pick < 0) pick = (s.dir + 1) % N;
        end
        r.dir = pick;
        r.len = BASE + lvl(sen, pick) * STEP;
      end
    end else if (s.ph == 1) begin
      for (int d = 0; d < N; d++) if (d != s.dir && lvl(sen, d) != 0) others = 1'b1;
      if (s.em) cut = !em[s.dir];
      else cut = done >= s.len || (done >= MING && lvl(sen, s.dir) == 0 && others) || ((em & ~(4'b1 << s.dir)) != 0);
      if (cut) begin
        r.ph = 2;
        r.el = 0;
        r.em = 1'b0;
        r.len = YT;
      end
    end else if (done >= YT) begin
      r.ph = 0;
      r.el = 0;
      r.len = ART;
    end
    return r;
  endfunction
  function automatic logic [20:0] expect_out(mstate_t s);
    logic [3:0] r = '1, y = '0, g = '0, rt = '0;
    if (s.ph != 0) r[s.dir] = 1'b0;
    if (s.ph == 1) begin
      g[s.dir] = 1'b1;
      rt[s.dir] = s.el < ((RT < s.len) ? RT : s.len);
    end
    if (s.ph == 2) y[s.dir] = 1'b1;
    return {r, y, g, rt, 2'(s.dir), 2'(s.ph), s.em};
  endfunction
  always @(posedge clk or negedge reset)
    if (!reset) m <= '{0, N - 1, 0, ART, 1'b0};
    else m <= model_next(m, sensor, emerg);
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic bound_fail(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask
  initial forever begin
    logic ok;
    @(negedge clk);
    check("model", 32'({red, yel, gs, gr, adir, ph, ea}), 32'(expect_out(m)));
    ok = $countones(~red) <= 1;
    for (int d = 0; d < N; d++) begin
      if (int'(red[d]) + int'(yel[d]) + int'(gs[d]) != 1) ok = 1'b0;
      if (gr[d] && !gs[d]) ok = 1'b0;
    end
    check("invariant", 32'(ok), 32'd1);
  end
  task automatic measure(int ph_exp, int start, output int cnt, output int rcnt);
    int d0 = int'(adir);
    cnt = start;
    rcnt = (gr != 0) ? 1 : 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (int'(ph) != ph_exp || int'(adir) != d0) return;
      cnt++;
      if (gr != 0) rcnt++;
    end
    bound_fail("measure");
  endtask
  task automatic wait_green(int d, int bound);
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (ph == 2'd1 && int'(adir) == d) return;
    end
    bound_fail("wait_green");
  endtask
  task automatic do_reset(logic [7:0] s, logic [3:0] e);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    sensor = s;
    emerg = e;
    reset = 1'b1;
  endtask
  initial begin
    sensor = 8'h55;
    repeat (3) @(negedge clk);
    check("rst_red", 32'(red), 32'hF);
    check("rst_lamps", 32'({yel, gs, gr}), 32'h0);
    check("rst_dir", 32'(adir), 32'd3);
    check("rst_phase", 32'(ph), 32'd0);
    check("rst_emerg", 32'(ea), 32'd0);
    reset = 1'b1;
    measure(0, 1, n, nr);
    check("t1_allred_len", n, 3);
    for (int k = 0; k < 5; k++) begin
      check("t1_order", 32'(adir), 32'(k % 4));
      measure(1, 1, n, nr);
      check("t1_green_len", n, 30);
      check("t1_right_len", nr, 8);
      measure(2, 1, n, nr);
      check("t1_yellow_len", n, 5);
      measure(0, 1, n, nr);
      check("t1_allred_len", n, 3);
    end
    do_reset(8'h03, 4'h0);
    measure(0, 1, n, nr);
    check("t2_dir0", 32'(adir), 32'd0);
    measure(1, 1, n, nr);
    check("t2_green_lvl3", n, 50);
    sensor = 8'h20;
    measure(2, 1, n, nr);
    measure(0, 1, n, nr);
    check("t2_skip", 32'(adir), 32'd2);
    measure(1, 1, n, nr);
    check("t2_green_lvl2", n, 40);
    do_reset(8'h55, 4'h0);
    measure(0, 1, n, nr);
    repeat (4) @(negedge clk);
    sensor = 8'h04;
    measure(1, 5, n, nr);
    check("t3_gapout_len", n, 10);
    measure(2, 1, n, nr);
    measure(0, 1, n, nr);
    check("t3_next_dir", 32'(adir), 32'd1);
    do_reset(8'h55, 4'h0);
    measure(0, 1, n, nr);
    repeat (2) @(negedge clk);
    emerg = 4'b0100;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) check("t4_cut", 32'({ph, ea}), 32'({2'd2, 1'b0}));
      if (k == 9) check("t4_em_green", 32'({ph, adir, ea}), 32'({2'd1, 2'd2, 1'b1}));
    end
    emerg = 4'b0000;
    check("t4_hold", 32'({ph, adir, ea}), 32'({2'd1, 2'd2, 1'b1}));
    @(negedge clk);
    check("t4_release", 32'({ph, ea}), 32'({2'd2, 1'b0}));
    do_reset(8'h55, 4'b1010);
    measure(0, 1, n, nr);
    check("t5_first", 32'({adir, ea}), 32'({2'd1, 1'b1}));
    repeat (10) @(negedge clk);
    emerg = 4'b1000;
    wait_green(3, 30);
    check("t5_second", 32'(ea), 32'd1);
    emerg = 4'b0000;
    wait_green(0, 30);
    check("t5_normal", 32'(ea), 32'd0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t5_async_red", 32'(red), 32'hF);
    check("t5_async_lamps", 32'({yel, gs, gr}), 32'h0);
    check("t5_async_state", 32'({adir, ph, ea}), 32'({2'd3, 2'd0, 1'b0}));
    @(negedge clk);
    reset = 1'b1;
    do_reset(8'h00, 4'h0);
    measure(0, 1, n, nr);
    check("t6_idle_dir", 32'(adir), 32'd0);
    measure(1, 1, n, nr);
    check("t6_idle_green", n, 20);
    check("t6_idle_right", nr, 8);
    measure(2, 1, n, nr);
    measure(0, 1, n, nr);
    check("t6_idle_next", 32'(adir), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
